ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch stage sitting directly downstream of the program counter register. It turns the current PC into a read request on the instruction memory port and captures the returned instruction together with its PC. The pair is buffered in a small FIFO and presented to decode with a valid/ready handshake. It drives the PC register's stall input for back-pressure and discards wrong-path work on a flush.

## Interface
- DEPTH, 4: queue entries (power of two, ≥2)
- RESET_PC, 64'h80000000: reset vector; must match the PC register's reset value
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- pc_i  in  64  current PC from the PC register
- flush_en_i  in  1  jump/flush from execute, same cycle as the PC register's jump
- imem_req_o  out  1  instruction read request
- imem_addr_o  out  64  read address (= pc_i)
- imem_rdata_i  in  32  read data, fixed 1-cycle latency, always ready
- stall_o  out  1  back-pressure to the PC register (holds PC)
- id_valid_o  out  1  instruction available to decode
- id_ready_i  in  1  decode accepts
- id_pc_o  out  64  PC of presented instruction
- id_inst_o  out  32  presented instruction

## Operation
- State registers:
  - count: entries stored, 0..DEPTH
  - wr_ptr / rd_ptr: log2(DEPTH)-bit pointers, wrap modulo DEPTH
  - infl: 1 if a request issued last cycle is still live
  - infl_pc: PC of that request
- stall_o = (count + infl ≥ DEPTH); combinational; a same-cycle pop does not relieve it.
- imem_req_o = rst & ~stall_o & ~flush_en_i; imem_addr_o = pc_i always.
- Issue: when imem_req_o=1, set infl←1 and infl_pc←pc_i; otherwise infl←0.
- Response: when infl=1, write {infl_pc, imem_rdata_i} at wr_ptr and increment wr_ptr.
- Pop: when id_valid_o & id_ready_i, increment rd_ptr.
- count update: count ← count + push − pop, where push and pop are evaluated in the same cycle.
- Flush, highest priority:
  - set count←0, rd_ptr←wr_ptr, infl←0
  - the response arriving in the flush cycle is dropped
  - no request is issued in the flush cycle, because pc_i is still the wrong path
- Overflow is impossible by construction. Verification asserts that count never exceeds DEPTH.
- Reset:
  - count=0, pointers=0, infl=0, infl_pc=RESET_PC
  - outputs: imem_req_o=0, stall_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0
- Stored entries hold their value while id_ready_i=0; id_* is stable until accepted.

## Timing
- Cycle t: pc_i=P, request issued.
- Cycle t+1: rdata valid and written into the queue.
- Cycle t+2: id_valid_o=1 with id_pc_o=P. Without bypass, PC-to-decode latency is 2 cycles.
- Steady state with id_ready_i=1: one instruction per cycle; stall_o never asserts.
- With id_ready_i=0:
  - stall_o asserts once count+infl reaches DEPTH
  - the PC holds
  - the same PC is re-requested in the first cycle stall_o drops
- Flush at cycle f:
  - id_valid_o=0 at f+1
  - target T is requested at f+1
  - T is presented at f+3 (f+2 with bypass)
- Flush concurrent with a pop: flush wins; the popped entry counts as consumed by decode.
- Reset asserted mid-operation: all state clears on the next edge; in-flight data is discarded.

## Configuration
- IFQ_BYPASS_EN defined:
  - when count=0 and infl=1, the response drives id_* combinationally in the arrival cycle
  - if id_ready_i=1, the response is not written
  - PC-to-decode latency becomes 1 cycle
- IFQ_BYPASS_EN undefined: id_* always comes from queue storage; latency is 2 cycles.

## Structure
- Package ifq_pkg holds:
  - DEPTH default
  - RESET_PC
  - entry width constant (96 bits: 64 PC + 32 instruction)
- Sub-module ifq_fifo: storage array, pointers, count and flush clear. The top module holds request, in-flight and bypass logic.

## Test plan
- Reset release, id_ready_i=1, imem returns 32'h00000013:
  - requests at 0x80000000, 0x80000004, …
  - id_pc_o=0x80000000 two cycles after the first request, then +4 each cycle
  - stall_o stays 0
- id_ready_i=0 for 10 cycles, DEPTH=4: stall_o rises after 4 outstanding/stored; no entry is lost or duplicated; on release, PCs continue in sequence.
- Flush in a cycle with 3 queued entries plus one in flight: next cycle id_valid_o=0 and count=0; target 0x80001000 is the next presented PC.
- Flush and pop in the same cycle with id_ready_i toggling every cycle: no stale PC is ever presented after the flush.
- rst=0 asserted mid-stream: next cycle all outputs are at their reset values; first request after release is 0x80000000.
- IFQ_BYPASS_EN, empty queue: id_pc_o equals the request PC one cycle after issue; count stays 0 under continuous id_ready_i.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared constants and the queue entry type for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned IFQ_DEPTH    = 4;
  localparam logic [63:0] IFQ_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned IFQ_ENTRY_W  = 96;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bundle: PC/flush in, instruction memory port, decode handshake.
interface ifetch_queue_if;

  logic [63:0] pc_i;
  logic        flush_en_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        stall_o;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [63:0] id_pc_o;
  logic [31:0] id_inst_o;

  // master = the fetch queue, slave = PC register / memory / decode side
  modport master (
    input  pc_i, flush_en_i, imem_rdata_i, id_ready_i,
    output imem_req_o, imem_addr_o, stall_o, id_valid_o, id_pc_o, id_inst_o
  );

  modport slave (
    output pc_i, flush_en_i, imem_rdata_i, id_ready_i,
    input  imem_req_o, imem_addr_o, stall_o, id_valid_o, id_pc_o, id_inst_o
  );

endinterface

// File: rtl/ifq_fifo.sv
// Circular buffer of {pc, inst} entries with occupancy count and a flush that
// discards everything stored (read pointer jumps to the write pointer).
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter  int unsigned DEPTH = IFQ_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  ifq_entry_t       data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output ifq_entry_t       head_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ifq_entry_t       mem_q [DEPTH];

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates validity, so stale
  // contents are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues PC reads, buffers {pc, inst}, back-pressures
// the PC register. Optional macro IFQ_BYPASS_EN presents responses in the
// arrival cycle when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = IFQ_DEPTH,
  parameter logic [63:0] RESET_PC = IFQ_RESET_PC
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             infl_q, infl_d;
  logic [63:0]      infl_pc_q, infl_pc_d;
  logic [CNT_W-1:0] count;
  ifq_entry_t       head, resp, id_entry;
  logic             stall, req, bypass, id_valid, accept, push, fifo_pop;

  always_comb begin
    resp.pc   = infl_pc_q;
    resp.inst = bus.imem_rdata_i;
    // In-flight requests reserve a slot, so the queue can never overflow.
    stall     = (count + CNT_W'(infl_q)) >= CNT_W'(DEPTH);
    req       = rst & ~stall & ~bus.flush_en_i;
`ifdef IFQ_BYPASS_EN
    bypass    = (count == '0) & infl_q;
`else
    bypass    = 1'b0;
`endif
    id_valid  = bypass | (count != '0);
    id_entry  = bypass ? resp : head;
    accept    = id_valid & bus.id_ready_i;
    // A bypassed response taken by decode this cycle never enters storage.
    push      = infl_q & ~(bypass & bus.id_ready_i);
    fifo_pop  = accept & ~bypass;
    infl_d    = req;
    infl_pc_d = req ? bus.pc_i : infl_pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      infl_q    <= 1'b0;
      infl_pc_q <= RESET_PC;
    end else begin
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (resp),
    .pop_i   (fifo_pop),
    .flush_i (bus.flush_en_i),
    .count_o (count),
    .head_o  (head)
  );

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = bus.pc_i;
  assign bus.stall_o     = stall;
  assign bus.id_valid_o  = id_valid;
  assign bus.id_pc_o     = id_valid ? id_entry.pc   : 64'h0;
  assign bus.id_inst_o   = id_valid ? id_entry.inst : 32'h0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: PC register and instruction memory models,
// a vector table for start-up/back-pressure, and hand sequences for flush/reset.
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int unsigned DEPTH = IFQ_DEPTH;
  localparam logic [63:0] R     = IFQ_RESET_PC;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        req;
    logic        stall;
    logic        valid;
    logic [63:0] addr;
    logic [63:0] pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if ifc ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int          errors  = 0;
  int          checks  = 0;
  int          accepts = 0;
  logic [63:0] exp_next;
  logic [63:0] pc_model;
  logic [63:0] target;
  vec_t        vecs [22];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {a[17:2], 16'h0013};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: memory answers last cycle's request, PC register updates.
  task automatic tick();
    logic        rst_p, fl_p, st_p, rq_p;
    logic [63:0] tg_p, ad_p;
    rst_p = rst;
    fl_p  = ifc.flush_en_i;
    st_p  = ifc.stall_o;
    rq_p  = ifc.imem_req_o;
    ad_p  = ifc.imem_addr_o;
    tg_p  = target;
    @(posedge clk);
    #1;
    ifc.imem_rdata_i = (rq_p === 1'b1) ? inst_of(ad_p) : 32'hdead_beef;
    if (rst_p !== 1'b1)     pc_model = R;
    else if (fl_p === 1'b1) pc_model = tg_p;
    else if (st_p !== 1'b1) pc_model = pc_model + 64'd4;
    ifc.pc_i = pc_model;
  endtask

  // In-order stream check: each accepted instruction is the next sequential PC.
  task automatic scoreboard();
    if (rst === 1'b1) begin
      if (ifc.id_valid_o === 1'b1 && ifc.id_ready_i === 1'b1) begin
        check("accept_pc", ifc.id_pc_o, exp_next);
        check("accept_inst", ifc.id_inst_o, inst_of(exp_next));
        exp_next = exp_next + 64'd4;
        accepts++;
      end
      if (ifc.flush_en_i === 1'b1) exp_next = target;
      check("count_bound", dut.u_fifo.count_q <= DEPTH, 1);
    end else begin
      exp_next = R;
    end
  endtask

  task automatic cycle(input logic r, input logic rdy, input logic fl, input logic [63:0] tg);
    tick();
    rst            = r;
    ifc.id_ready_i = rdy;
    ifc.flush_en_i = fl;
    target         = tg;
    #4;
    scoreboard();
  endtask

  task automatic row(input int i, input logic r, input logic rdy, input logic st,
                     input logic vd, input int aoff, input int poff);
    vecs[i] = '{rst: r, rdy: rdy, req: r & ~st, stall: st, valid: vd,
                addr: R + 64'(aoff), pc: vd ? R + 64'(poff) : 64'h0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          acc0;
    logic [63:0] t;

    rst              = 1'b0;
    ifc.pc_i         = R;
    ifc.flush_en_i   = 1'b0;
    ifc.id_ready_i   = 1'b1;
    ifc.imem_rdata_i = 32'h0;
    pc_model         = R;
    exp_next         = R;
    target           = 64'h0;

    // Reset, start-up at one per cycle, 10 cycles of back-pressure, release.
    row(0, 0, 1, 0, 0, 0, 0);
    row(1, 1, 1, 0, 0, 0, 0);
`ifdef IFQ_BYPASS_EN
    row(2, 1, 1, 0, 1, 4, 0);
    row(3, 1, 1, 0, 1, 8, 4);
    row(4, 1, 1, 0, 1, 12, 8);
    row(5, 1, 1, 0, 1, 16, 12);
    row(6, 1, 0, 0, 1, 20, 16);
    row(7, 1, 0, 0, 1, 24, 16);
    row(8, 1, 0, 0, 1, 28, 16);
    for (int k = 9; k <= 15; k++) row(k, 1, 0, 1, 1, 32, 16);
    row(16, 1, 1, 1, 1, 32, 16);
    row(17, 1, 1, 0, 1, 32, 20);
    row(18, 1, 1, 0, 1, 36, 24);
    row(19, 1, 1, 0, 1, 40, 28);
    row(20, 1, 1, 0, 1, 44, 32);
    row(21, 1, 1, 0, 1, 48, 36);
`else
    row(2, 1, 1, 0, 0, 4, 0);
    row(3, 1, 1, 0, 1, 8, 0);
    row(4, 1, 1, 0, 1, 12, 4);
    row(5, 1, 1, 0, 1, 16, 8);
    row(6, 1, 0, 0, 1, 20, 12);
    row(7, 1, 0, 0, 1, 24, 12);
    for (int k = 8; k <= 15; k++) row(k, 1, 0, 1, 1, 28, 12);
    row(16, 1, 1, 1, 1, 28, 12);
    row(17, 1, 1, 0, 1, 28, 16);
    row(18, 1, 1, 0, 1, 32, 20);
    row(19, 1, 1, 0, 1, 36, 24);
    row(20, 1, 1, 0, 1, 40, 28);
    row(21, 1, 1, 0, 1, 44, 32);
`endif

    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].rst, vecs[i].rdy, 1'b0, 64'h0);
      check($sformatf("v%0d_req", i),   ifc.imem_req_o,  vecs[i].req);
      check($sformatf("v%0d_addr", i),  ifc.imem_addr_o, vecs[i].addr);
      check($sformatf("v%0d_stall", i), ifc.stall_o,     vecs[i].stall);
      check($sformatf("v%0d_valid", i), ifc.id_valid_o,  vecs[i].valid);
      check($sformatf("v%0d_pc", i),    ifc.id_pc_o,     vecs[i].pc);
      check($sformatf("v%0d_inst", i),  ifc.id_inst_o,
            vecs[i].valid ? 64'(inst_of(vecs[i].pc)) : 64'h0);
`ifdef IFQ_BYPASS_EN
      if (i >= 1 && i <= 5) check($sformatf("v%0d_byp_count", i), dut.u_fifo.count_q, 0);
`endif
    end

    // Flush with 3 queued entries and one in flight.
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 1'b0, 64'h0);
      n++;
    end while (ifc.stall_o !== 1'b1 && n < 12);
    check("flush_setup_stall", ifc.stall_o, 1);
    check("flush_setup_count", dut.u_fifo.count_q, 3);
    t              = 64'h8000_1000;
    ifc.flush_en_i = 1'b1;
    target         = t;
    exp_next       = t;
    #1;
    check("flush_cycle_req", ifc.imem_req_o, 0);
    cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check("flush_f1_valid", ifc.id_valid_o, 0);
    check("flush_f1_stall", ifc.stall_o, 0);
    check("flush_f1_count", dut.u_fifo.count_q, 0);
    check("flush_f1_req", ifc.imem_req_o, 1);
    check("flush_f1_addr", ifc.imem_addr_o, t);
    for (int k = 2; k <= 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 64'h0);
      if (k - 1 == LAT) begin
        check($sformatf("flush_f%0d_valid", k), ifc.id_valid_o, 1);
        check($sformatf("flush_f%0d_pc", k), ifc.id_pc_o, t);
      end else if (k - 1 < LAT) begin
        check($sformatf("flush_f%0d_valid", k), ifc.id_valid_o, 0);
      end
    end

    // Flushes colliding with pops while decode toggles ready every cycle.
    acc0 = accepts;
    for (int i = 0; i < 30; i++) begin
      logic fl;
      fl = (i == 5) || (i == 11) || (i == 12) || (i == 17) || (i == 18);
      cycle(1'b1, i[0], fl, 64'h8000_2000 + 64'(i) * 64'h100);
    end
    check("toggle_progress", (accepts - acc0) >= 3, 1);

    // Reset asserted mid-stream.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("rst_req", ifc.imem_req_o, 0);
    check("rst_stall", ifc.stall_o, 0);
    check("rst_valid", ifc.id_valid_o, 0);
    check("rst_pc", ifc.id_pc_o, 0);
    check("rst_inst", ifc.id_inst_o, 0);
    cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check("rst_rel_req", ifc.imem_req_o, 1);
    check("rst_rel_addr", ifc.imem_addr_o, R);
    acc0 = accepts;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check("rst_rel_progress", (accepts - acc0) >= 4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
